muldiv_unit: RTL

Shared iterative RV32M multiply/divide unit serving both harts of `cpu_top`. It sits directly downstream of the core's `muldiv_*` request port. It accepts one tagged operation at a time and returns the result with the issuing hart ID and destination register. The core then writes the result back into the banked register file.

---
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core's muldiv port and the shared
// RV32M multiply/divide unit.
interface muldiv_unit_if #(
   parameter int XLEN       = 32,
   parameter int HART_ID_W  = 1,
   parameter int REG_ADDR_W = 5
);
   logic                  muldiv_start;
   logic [2:0]            muldiv_op;
   logic [XLEN-1:0]       muldiv_a;
   logic [XLEN-1:0]       muldiv_b;
   logic [HART_ID_W-1:0]  muldiv_hart_id;
   logic [REG_ADDR_W-1:0] muldiv_rd;
   logic                  muldiv_busy;
   logic                  muldiv_done;
   logic [XLEN-1:0]       muldiv_result;
   logic [HART_ID_W-1:0]  muldiv_done_hart_id;
   logic [REG_ADDR_W-1:0] muldiv_done_rd;

   modport master (
      output muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
      input  muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd
   );

   modport slave (
      input  muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
      output muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd
   );
endinterface

// File: rtl/muldiv_unit.sv
// Shared iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fix-up at completion.
module muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int HART_ID_W  = 1,
   parameter int REG_ADDR_W = 5
) (
   input logic         clk,
   input logic         rst,
   muldiv_unit_if.slave md
);
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [2:0]            op_q, op_d;
   logic [2*XLEN-1:0]     acc_q, acc_d;
   logic [XLEN-1:0]       opnd_q, opnd_d;
   logic [XLEN-1:0]       a_q, a_d;
   logic                  neg_q, neg_d;
   logic                  div0_q, div0_d;
   logic                  ovf_q, ovf_d;
   logic [HART_ID_W-1:0]  hart_q, hart_d, done_hart_q, done_hart_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d, done_rd_q, done_rd_d;
   logic [XLEN-1:0]       res_q, res_d;

   logic                  sgn_a, sgn_b;
   logic [XLEN-1:0]       mag_a, mag_b;
   logic [XLEN:0]         mul_sum, div_trial;
   logic [2*XLEN-1:0]     prod;
   logic [XLEN-1:0]       quo_raw, rem_raw, quo, rem;

   // Effective operand signs for the request currently presented on the port.
   assign sgn_a = md.muldiv_a[XLEN-1] & (md.muldiv_op == 3'd1 || md.muldiv_op == 3'd2 ||
                                         md.muldiv_op == 3'd4 || md.muldiv_op == 3'd6);
   assign sgn_b = md.muldiv_b[XLEN-1] & (md.muldiv_op == 3'd1 || md.muldiv_op == 3'd4 ||
                                         md.muldiv_op == 3'd6);
   assign mag_a = sgn_a ? -md.muldiv_a : md.muldiv_a;
   assign mag_b = sgn_b ? -md.muldiv_b : md.muldiv_b;

   // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
   assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};

   assign prod    = neg_q ? -acc_q : acc_q;
   assign quo_raw = acc_q[XLEN-1:0];
   assign rem_raw = acc_q[2*XLEN-1:XLEN];
   assign quo     = neg_q ? -quo_raw : quo_raw;
   assign rem     = neg_q ? -rem_raw : rem_raw;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      acc_d       = acc_q;
      opnd_d      = opnd_q;
      a_d         = a_q;
      neg_d       = neg_q;
      div0_d      = div0_q;
      ovf_d       = ovf_q;
      hart_d      = hart_q;
      rd_d        = rd_q;
      done_hart_d = done_hart_q;
      done_rd_d   = done_rd_q;
      res_d       = res_q;

      unique case (state_q)
         S_IDLE: begin
            if (md.muldiv_start) begin
               state_d = S_CALC;
               cnt_d   = '0;
               op_d    = md.muldiv_op;
               hart_d  = md.muldiv_hart_id;
               rd_d    = md.muldiv_rd;
               a_d     = md.muldiv_a;
               div0_d  = (md.muldiv_b == '0);
               ovf_d   = (md.muldiv_a == SMIN) && (md.muldiv_b == '1) &&
                         (md.muldiv_op == 3'd4 || md.muldiv_op == 3'd6);
               neg_d   = (md.muldiv_op == 3'd6) ? sgn_a : (sgn_a ^ sgn_b);
               if (md.muldiv_op[2]) begin
                  acc_d  = {{XLEN{1'b0}}, mag_a};
                  opnd_d = mag_b;
               end else begin
                  acc_d  = {{XLEN{1'b0}}, mag_b};
                  opnd_d = mag_a;
               end
            end
         end
         S_CALC: begin
            if (cnt_q == CW'(XLEN)) begin
               state_d     = S_DONE;
               done_hart_d = hart_q;
               done_rd_d   = rd_q;
               unique case (op_q)
                  3'd0:                res_d = prod[XLEN-1:0];
                  3'd1, 3'd2, 3'd3:    res_d = prod[2*XLEN-1:XLEN];
                  3'd4, 3'd5:          res_d = div0_q ? '1 : (ovf_q ? SMIN : quo);
                  default:             res_d = div0_q ? a_q : (ovf_q ? '0 : rem);
               endcase
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (op_q[2]) begin
                  acc_d = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                          : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
               end else begin
                  acc_d = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                                   : {1'b0, acc_q[2*XLEN-1:1]};
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         acc_q       <= '0;
         opnd_q      <= '0;
         a_q         <= '0;
         neg_q       <= 1'b0;
         div0_q      <= 1'b0;
         ovf_q       <= 1'b0;
         hart_q      <= '0;
         rd_q        <= '0;
         done_hart_q <= '0;
         done_rd_q   <= '0;
         res_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         opnd_q      <= opnd_d;
         a_q         <= a_d;
         neg_q       <= neg_d;
         div0_q      <= div0_d;
         ovf_q       <= ovf_d;
         hart_q      <= hart_d;
         rd_q        <= rd_d;
         done_hart_q <= done_hart_d;
         done_rd_q   <= done_rd_d;
         res_q       <= res_d;
      end
   end

   assign md.muldiv_busy         = (state_q != S_IDLE);
   assign md.muldiv_done         = (state_q == S_DONE);
   assign md.muldiv_result       = res_q;
   assign md.muldiv_done_hart_id = done_hart_q;
   assign md.muldiv_done_rd      = done_rd_q;
endmodule
